// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Counter must be able to hold the value WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used once per cycle by the serial datapath.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   logic half_sum;

   assign half_sum = a_i ^ b_i;
   assign s_o      = half_sum ^ cin_i;
   assign cout_o   = (a_i & b_i) | (cin_i & half_sum);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first. The result
// is shifted in from the MSB side, so after WIDTH shifts it is aligned.
// Outputs are decoded from registers only.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_cout;

   full_adder u_full_adder (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .cin_i  (carry_q),
      .s_o    (fa_s),
      .cout_o (fa_cout)
   );

   // Next-state and datapath update; every register holds by default.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               carry_d = cin_i;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               // Publish the fully shifted result on the edge entering DONE.
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q == SHIFT);
   assign done_o = (state_q == DONE);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16.
`timescale 1ns/1ps
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;

   logic        start8 = 1'b0, cin8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, cout8;
   logic [7:0]  sum8;

   logic        start16 = 1'b0, cin16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, cout16;
   logic [15:0] sum16;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t vecs[8];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rstn_i(rstn), .start_i(start8), .a_i(a8), .b_i(b8),
      .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk_i(clk), .rstn_i(rstn), .start_i(start16), .a_i(a16), .b_i(b16),
      .cin_i(cin16), .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // busy and done must never be high together
   always @(negedge clk) begin
      if (done8) begin
         n_chk++;
         if (busy8) begin n_fail++; $display("FAIL busy_done_overlap8: got busy=1, expected 0"); end
      end
      if (done16) begin
         n_chk++;
         if (busy16) begin n_fail++; $display("FAIL busy_done_overlap16: got busy=1, expected 0"); end
      end
   end

   // One full 8-bit operation; called #1 after an edge with dut8 in IDLE.
   task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic ec);
      int lat;
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      chk({nm, "_busy"}, longint'(busy8), 1);
      lat = 0;
      while (!done8 && lat < 20) begin @(posedge clk); #1; lat++; end
      chk({nm, "_latency"}, longint'(lat), 8);
      chk({nm, "_sum"}, longint'(sum8), longint'(es));
      chk({nm, "_cout"}, longint'(cout8), longint'(ec));
      @(posedge clk); #1;
      chk({nm, "_done_width"}, longint'(done8), 0);
      chk({nm, "_sum_hold"}, longint'(sum8), longint'(es));
      $display("op %s: %02h+%02h+%0d -> cout=%0d sum=%02h lat=%0d", nm, a, b, c, cout8, sum8, lat);
   endtask

   // Back-to-back random operations on the selected instance.
   task automatic rand_ops(input int w, input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] ra, rb;
         logic        rc;
         longint      exp, act;
         int          cyc;
         logic        bz, dn;
         ra = $urandom; rb = $urandom; rc = 1'($urandom);
         if (w == 8) begin
            ra &= 32'hFF; rb &= 32'hFF;
            a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc; start8 = 1'b1;
         end else begin
            ra &= 32'hFFFF; rb &= 32'hFFFF;
            a16 = ra[15:0]; b16 = rb[15:0]; cin16 = rc; start16 = 1'b1;
         end
         exp = longint'(ra) + longint'(rb) + longint'(rc);
         cyc = 0;
         bz = (w == 8) ? busy8 : busy16;
         while (!bz && cyc < 6) begin
            @(posedge clk); #1; cyc++;
            bz = (w == 8) ? busy8 : busy16;
         end
         if (!bz) chk($sformatf("rand%0d_accept_timeout", w), 0, 1);
         start8 = 1'b0; start16 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
         cyc = 0;
         dn = (w == 8) ? done8 : done16;
         while (!dn && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            dn = (w == 8) ? done8 : done16;
         end
         if (!dn) chk($sformatf("rand%0d_done_timeout", w), 0, 1);
         act = (w == 8) ? longint'({cout8, sum8}) : longint'({cout16, sum16});
         chk($sformatf("rand%0d_result_%0d", w, k), act, exp);
         $display("rand w=%0d #%0d: %0h+%0h+%0d -> %0h", w, k, ra, rb, rc, act);
      end
   endtask

   initial begin
      int pulses, busies;
      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[7] = '{8'h3C, 8'h47, 1'b0, 8'h83, 1'b0};

      // reset state, with start held high to show it is ignored in reset
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy8", longint'(busy8), 0);
      chk("reset_done8", longint'(done8), 0);
      chk("reset_sum8", longint'({cout8, sum8}), 0);
      chk("reset_out16", longint'({busy16, done16, cout16, sum16}), 0);
      start8 = 1'b0;
      rstn = 1'b1;

      // table: first vector starts on the very first edge after release
      for (int i = 0; i < 8; i++)
         run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);

      // start held during SHIFT and DONE is ignored
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      a8 = 8'hAA;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done8) pulses++;
      end
      chk("ignore_start_done_at_8", longint'(done8), 1);
      chk("ignore_start_sum", longint'({cout8, sum8}), 32'h046);
      @(posedge clk); #1;
      start8 = 1'b0;
      busies = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done8) pulses++;
         if (busy8) busies++;
      end
      chk("ignore_start_pulses", longint'(pulses), 1);
      chk("ignore_start_no_requeue", longint'(busies), 0);
      chk("ignore_start_sum_hold", longint'(sum8), 32'h46);
      $display("op ignore_start: 12+34 -> sum=%02h pulses=%0d", sum8, pulses);

      // reset at shift 4 aborts the operation
      a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("abort_busy_before", longint'(busy8), 1);
      rstn = 1'b0;
      #1;
      chk("abort_outputs_cleared", longint'({busy8, done8, cout8, sum8}), 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      pulses = 0;
      busies = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done8) pulses++;
         if (busy8) busies++;
      end
      chk("abort_no_done", longint'(pulses), 0);
      chk("abort_no_busy", longint'(busies), 0);
      $display("op abort: 55+55 reset at shift 4 -> pulses=%0d", pulses);
      run8("after_abort", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

      // random back-to-back traffic on both widths
      rand_ops(8, 1000);
      rand_ops(16, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
